// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module : wb_burst_master
// Brief  : Wishbone B3 initiator moving 32-bit word blocks between a local
//          stream and a word-addressed slave. Define WB_BURST_MASTER_BURST_EN
//          for incrementing bursts; otherwise every beat is a classic cycle.
// Rev    : 1.0  initial release
// ============================================================================
module wb_burst_master #(
  parameter int ADR_WIDTH = 10,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADR_WIDTH-1:0] cmd_adr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic [31:0]          wdata_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  output logic [31:0]          rdata_o,
  output logic                 rdata_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [31:0]          dat_o,
  input  logic [31:0]          dat_i,
  output logic [3:0]           sel_o,
  output logic [2:0]           cti_o,
  input  logic                 ack_i
);

`ifdef WB_BURST_MASTER_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_BUS   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 we_q, we_d;
  logic [31:0]          dat_q, dat_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                 bus_active;
  logic                 last_beat;
  logic [2:0]           cti;
  logic                 wready;

  assign bus_active = (state_q == S_BUS);
  assign last_beat  = (rem_q == LEN_WIDTH'(1));

  // A burst continues only while the next word is known to be available.
  always_comb begin
    cti = CTI_CLASSIC;
    if (BURST_EN) begin
      if (!last_beat && (!we_q || wdata_valid_i)) begin
        cti = CTI_INCR;
      end else begin
        cti = CTI_END;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    rem_d    = rem_q;
    we_d     = we_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    tmo_d    = tmo_q;
    wready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ready_q && cmd_valid_i) begin
          adr_d = cmd_adr_i;
          rem_d = cmd_len_i;
          we_d  = cmd_we_i;
          err_d = 1'b0;
          tmo_d = '0;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else if (cmd_we_i) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_BUS;
          end
        end
      end

      S_WDATA: begin
        if (wdata_valid_i) begin
          wready  = 1'b1;
          dat_d   = wdata_i;
          tmo_d   = '0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        if (ack_i) begin
          adr_d = adr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          tmo_d = '0;
          if (!we_q) begin
            rdata_d  = dat_i;
            rvalid_d = 1'b1;
          end else if (BURST_EN && !last_beat && wdata_valid_i) begin
            dat_d  = wdata_i;
            wready = 1'b1;
          end
          if (!BURST_EN || (cti == CTI_END)) begin
            state_d = S_GAP;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_GAP: begin
        tmo_d = '0;
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (we_q) begin
          state_d = S_WDATA;
        end else begin
          state_d = S_BUS;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Hold off new commands during the completion pulse so busy_o stays clean.
    ready_d = (state_d == S_IDLE) && !done_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      rem_q    <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cmd_ready_o   = ready_q;
  assign wdata_ready_o = wready;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign busy_o        = (state_q != S_IDLE) || done_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign cyc_o         = bus_active;
  assign stb_o         = bus_active;
  assign we_o          = bus_active && we_q;
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign sel_o         = 4'b1111;
  assign cti_o         = bus_active ? cti : CTI_CLASSIC;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_burst_master
// Brief  : Scoreboard bench for wb_burst_master against a one-wait-state slave.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_burst_master;

  localparam int AW  = 10;
  localparam int LW  = 8;
  localparam int TMO = 8;

`ifdef WB_BURST_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [LW-1:0] cmd_len_i;
  logic [31:0]   wdata_i;
  logic          wdata_valid_i, wdata_ready_o;
  logic [31:0]   rdata_o;
  logic          rdata_valid_o, busy_o, done_o, err_o;
  logic          cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o, dat_i;
  logic [3:0]    sel_o;
  logic [2:0]    cti_o;
  logic          ack_i;

  wb_burst_master #(.ADR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .cti_o(cti_o), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [2:0]    cti;
  } beat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wq[$];
  logic [31:0] mem [0:(1<<AW)-1];

  int  errors = 0;
  int  checks = 0;
  int  cyc_starts = 0, cyc_hi = 0, wr_took = 0, consumed = 0;
  int  stall_at = -1, stall_left = 0;
  bit  no_ack = 1'b0;
  bit  cyc_prev = 1'b0;
  bit  took;

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_9E37);
  endfunction

  function automatic logic [2:0] cti_for(input bit last);
    if (!BURST) return 3'b000;
    return last ? 3'b111 : 3'b010;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave: acks one cycle after strobe, reloads memory pattern on reset.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ack_i <= 1'b0;
      dat_i <= 32'h0;
      for (int a = 0; a < (1 << AW); a++) mem[a] <= pat(a);
    end else begin
      if (cyc_o && stb_o && !ack_i && !no_ack) begin
        ack_i <= 1'b1;
        dat_i <= mem[adr_o];
      end else begin
        ack_i <= 1'b0;
      end
      if (cyc_o && stb_o && we_o && ack_i) mem[adr_o] <= dat_o;
    end
  end

  // Write stream source with an optional stall after a given word count.
  initial begin
    wdata_valid_i = 1'b0;
    wdata_i       = 32'h0;
    forever begin
      @(negedge clk);
      took = wdata_valid_i && wdata_ready_o;
      @(posedge clk);
      #1;
      if (took) begin
        void'(wq.pop_front());
        consumed++;
      end
      if (consumed == stall_at && stall_left > 0) begin
        stall_left--;
        wdata_valid_i = 1'b0;
      end else begin
        wdata_valid_i = (wq.size() > 0);
      end
      wdata_i = (wq.size() > 0) ? wq[0] : 32'h0;
    end
  end

  // Monitor: compares bus beats and read words against the scoreboard.
  initial begin
    beat_t       b;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        cyc_prev = 1'b0;
      end else begin
        if (cyc_o) cyc_hi++;
        if (cyc_o && !cyc_prev) cyc_starts++;
        cyc_prev = cyc_o;
        if (wdata_valid_i && wdata_ready_o) wr_took++;
        if (cyc_o && stb_o && ack_i) begin
          if (exp_beat.size() == 0) begin
            check_val("beat_unexpected", 32'(adr_o), 32'hFFFF_FFFF);
          end else begin
            b = exp_beat.pop_front();
            check_val("beat_adr", 32'(adr_o), 32'(b.adr));
            check_val("beat_cti", 32'(cti_o), 32'(b.cti));
          end
        end
        if (rdata_valid_o) begin
          if (exp_rd.size() == 0) begin
            check_val("rdata_unexpected", rdata_o, 32'hFFFF_FFFF);
          end else begin
            d = exp_rd.pop_front();
            check_val("rdata", rdata_o, d);
          end
        end
      end
    end
  end

  task automatic push_beats(input logic [AW-1:0] adr, input int len);
    logic [AW-1:0] a;
    a = adr;
    for (int i = 0; i < len; i++) begin
      exp_beat.push_back('{adr: a, cti: cti_for(i == len - 1)});
      a = a + 1'b1;
    end
  endtask

  task automatic push_reads(input logic [AW-1:0] adr, input int len);
    logic [AW-1:0] a;
    a = adr;
    for (int i = 0; i < len; i++) begin
      exp_rd.push_back(pat(int'(a)));
      a = a + 1'b1;
    end
  endtask

  task automatic issue_cmd(input logic we, input logic [AW-1:0] adr, input logic [LW-1:0] len,
                           input string tag);
    int n;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = len;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready_o && n < 50);
    check_val({tag, "_accept"}, 32'(cmd_ready_o), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [LW-1:0] len,
                         input logic exp_err, input int exp_starts, input int exp_hi,
                         input string tag, output int lat);
    int s0, h0;
    bit got;
    issue_cmd(we, adr, len, tag);
    s0  = cyc_starts;
    h0  = cyc_hi;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) check_val({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (done_o) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check_val({tag, "_done_seen"}, 32'(got), 32'd1);
    check_val({tag, "_err"}, 32'(err_o), 32'(exp_err));
    check_val({tag, "_cyc_count"}, 32'(cyc_starts - s0), 32'(exp_starts));
    if (exp_hi >= 0) check_val({tag, "_cyc_len"}, 32'(cyc_hi - h0), 32'(exp_hi));
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check_val({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int lat, t0;
    logic [31:0] w [4];
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_len_i   = '0;

    repeat (3) @(negedge clk);
    check_val("rst_ctrl", 32'({cyc_o, stb_o, we_o, busy_o, done_o, err_o, rdata_valid_o,
                               cmd_ready_o, wdata_ready_o}), 32'd0);
    check_val("rst_adr", 32'(adr_o), 32'd0);
    check_val("rst_dat", dat_o, 32'd0);
    check_val("rst_cti", 32'(cti_o), 32'd0);
    check_val("rst_sel", 32'(sel_o), 32'hF);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_val("ready_after_release", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    check_val("ready_one_cycle_later", 32'(cmd_ready_o), 32'd1);

    // Single-word read.
    push_beats(10'd5, 1);
    push_reads(10'd5, 1);
    run_cmd(1'b0, 10'd5, 8'd1, 1'b0, 1, -1, "rd1", lat);

    // Four-word write with data always available.
    for (int i = 0; i < 4; i++) begin
      w[i] = 32'h5A00_0000 + 32'(i * 32'h111);
      wq.push_back(w[i]);
    end
    push_beats(10'd10, 4);
    t0 = wr_took;
    run_cmd(1'b1, 10'd10, 8'd4, 1'b0, BURST ? 1 : 4, -1, "wr4", lat);
    check_val("wr4_wready_pulses", 32'(wr_took - t0), 32'd4);
    for (int i = 0; i < 4; i++) check_val("wr4_mem", mem[10 + i], w[i]);

    // Four-word write with the stream stalling after two words.
    for (int i = 0; i < 4; i++) begin
      w[i] = 32'h3C00_0000 ^ 32'(i * 32'h1357);
      wq.push_back(w[i]);
    end
    stall_at   = consumed + 2;
    stall_left = 6;
    exp_beat.push_back('{adr: 10'd20, cti: BURST ? 3'b010 : 3'b000});
    exp_beat.push_back('{adr: 10'd21, cti: BURST ? 3'b111 : 3'b000});
    exp_beat.push_back('{adr: 10'd22, cti: BURST ? 3'b010 : 3'b000});
    exp_beat.push_back('{adr: 10'd23, cti: BURST ? 3'b111 : 3'b000});
    run_cmd(1'b1, 10'd20, 8'd4, 1'b0, BURST ? 2 : 4, -1, "wrstall", lat);
    for (int i = 0; i < 4; i++) check_val("wrstall_mem", mem[20 + i], w[i]);

    // Read across the top of the address space.
    push_beats(10'd1023, 3);
    push_reads(10'd1023, 3);
    run_cmd(1'b0, 10'd1023, 8'd3, 1'b0, BURST ? 1 : 3, -1, "rdwrap", lat);

    // Slave never acknowledges.
    no_ack = 1'b1;
    run_cmd(1'b0, 10'd100, 8'd2, 1'b1, 1, TMO, "tmo", lat);
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_val("tmo_err_held", 32'(err_o), 32'd1);

    // Zero-length command.
    run_cmd(1'b0, 10'd50, 8'd0, 1'b0, 0, 0, "len0", lat);
    check_val("len0_latency", 32'(lat), 32'd0);

    // Reset in the middle of a long read.
    push_beats(10'd300, 20);
    push_reads(10'd300, 20);
    issue_cmd(1'b0, 10'd300, 8'd20, "rstmid");
    repeat (6) @(posedge clk);
    #1 rst_i = 1'b1;
    #1;
    check_val("rstmid_ctrl", 32'({cyc_o, stb_o, we_o, busy_o, done_o, err_o, rdata_valid_o,
                                  cmd_ready_o, wdata_ready_o}), 32'd0);
    check_val("rstmid_adr_cti", 32'({adr_o, cti_o}), 32'd0);
    exp_beat.delete();
    exp_rd.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    t0 = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_o) t0++;
    end
    check_val("rstmid_no_done", 32'(t0), 32'd0);

    // Normal operation after the abort.
    push_beats(10'd7, 2);
    push_reads(10'd7, 2);
    run_cmd(1'b0, 10'd7, 8'd2, 1'b0, BURST ? 1 : 2, -1, "rdpost", lat);

    repeat (3) @(negedge clk);
    check_val("beats_left", 32'(exp_beat.size()), 32'd0);
    check_val("reads_left", 32'(exp_rd.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
